// File: rtl/cache_req_arbiter_if.sv
// Request/response bundle between two requesters (R, S), the arbiter and the cache controller.
// master = requester/controller side, slave = arbiter side.
interface cache_req_arbiter_if #(
   parameter int TAG_LEN = 8
);
   logic               reqR_valid;
   logic               reqR_opcode;
   logic [TAG_LEN-1:0] reqR_addr;
   logic               reqR_ready;
   logic               respR_valid;
   logic               respR_hit;

   logic               reqS_valid;
   logic               reqS_opcode;
   logic [TAG_LEN-1:0] reqS_addr;
   logic               reqS_ready;
   logic               respS_valid;
   logic               respS_hit;

   logic               ctrl_valid;
   logic               ctrl_opcode;
   logic [TAG_LEN-1:0] ctrl_addr;
   logic               ctrl_resp_valid;
   logic               ctrl_resp_hit;
   logic               ctrl_stall;

   modport master (
      output reqR_valid, reqR_opcode, reqR_addr,
      input  reqR_ready, respR_valid, respR_hit,
      output reqS_valid, reqS_opcode, reqS_addr,
      input  reqS_ready, respS_valid, respS_hit,
      input  ctrl_valid, ctrl_opcode, ctrl_addr,
      output ctrl_resp_valid, ctrl_resp_hit, ctrl_stall
   );

   modport slave (
      input  reqR_valid, reqR_opcode, reqR_addr,
      output reqR_ready, respR_valid, respR_hit,
      input  reqS_valid, reqS_opcode, reqS_addr,
      output reqS_ready, respS_valid, respS_hit,
      output ctrl_valid, ctrl_opcode, ctrl_addr,
      input  ctrl_resp_valid, ctrl_resp_hit, ctrl_stall
   );
endinterface

// File: rtl/cache_req_arbiter.sv
// Round-robin R/S cache request arbiter, one request in flight; issue 2 cycles after push, response 1 cycle after ctrl_resp.
// Backpressure: reqX_ready low while that FIFO holds DEPTH entries; stalled requests are re-issued and keep the grant.
module cache_req_arbiter #(
   parameter int TAG_LEN = 8,
   parameter int DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cache_req_arbiter_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic REQ_R = 1'b0;
   localparam logic REQ_S = 1'b1;

   typedef struct packed {
      logic               opcode;
      logic [TAG_LEN-1:0] addr;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t     state, state_nxt;
   entry_t     in_ent    [2];
   entry_t     fifo_head [2];
   logic [1:0] push, pop, ready, nonempty;

   entry_t     cur;
   logic       owner;
   logic       last_grant;
   logic       gnt;
   logic [1:0] resp_vld, resp_hit;

   logic       latch_en, resp_done, ctrl_valid_c;

   assign in_ent[0] = {bus.reqR_opcode, bus.reqR_addr};
   assign in_ent[1] = {bus.reqS_opcode, bus.reqS_addr};
   assign push      = {bus.reqS_valid & ready[1], bus.reqR_valid & ready[0]};
   assign pop[0]    = resp_done & (owner == REQ_R);
   assign pop[1]    = resp_done & (owner == REQ_S);

   genvar g;
   for (g = 0; g < 2; g++) begin : g_fifo
      entry_t        mem [DEPTH];
      logic [PW-1:0] wr_ptr, rd_ptr;
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[g]) wr_ptr <= wr_ptr + 1'b1;
            if (pop[g])  rd_ptr <= rd_ptr + 1'b1;
            if (push[g] && !pop[g])
               count <= count + 1'b1;
            else if (pop[g] && !push[g])
               count <= count - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (push[g]) mem[wr_ptr] <= in_ent[g];
      end

      assign fifo_head[g] = mem[rd_ptr];
      assign ready[g]     = (count != FULL);
      assign nonempty[g]  = (count != '0);
   end

   // Under contention the requester not served last wins; otherwise the only non-empty one.
   assign gnt = (&nonempty) ? ~last_grant : ~nonempty[0];

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (|nonempty) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (bus.ctrl_resp_valid)
                      state_nxt = bus.ctrl_stall ? ST_ISSUE : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      latch_en     = 1'b0;
      resp_done    = 1'b0;
      ctrl_valid_c = 1'b0;
      case (state)
         ST_IDLE:  latch_en     = |nonempty;
         ST_ISSUE: ctrl_valid_c = 1'b1;
         ST_WAIT:  resp_done    = bus.ctrl_resp_valid & ~bus.ctrl_stall;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur        <= '0;
         owner      <= REQ_R;
         last_grant <= REQ_S;
         resp_vld   <= '0;
         resp_hit   <= '0;
      end else begin
         if (latch_en) begin
            owner <= gnt;
            cur   <= fifo_head[gnt];
         end
         if (resp_done) last_grant <= owner;
         resp_vld <= pop;
         resp_hit <= pop & {2{bus.ctrl_resp_hit}};
      end
   end

   assign bus.reqR_ready  = ready[0];
   assign bus.reqS_ready  = ready[1];
   assign bus.respR_valid = resp_vld[0];
   assign bus.respR_hit   = resp_hit[0];
   assign bus.respS_valid = resp_vld[1];
   assign bus.respS_hit   = resp_hit[1];
   assign bus.ctrl_valid  = ctrl_valid_c;
   assign bus.ctrl_opcode = cur.opcode;
   assign bus.ctrl_addr   = cur.addr;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: reset, latency, fairness, stall retry, full/wrap, mid-flight reset.
module tb_cache_req_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_req_arbiter_if #(.TAG_LEN(8)) bus ();

   cache_req_arbiter #(.TAG_LEN(8), .DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // Passive monitor, sampled on the falling edge.
   logic [7:0] issue_log [$];
   int   resp_r_cnt = 0;
   int   resp_s_cnt = 0;
   int   viol       = 0;
   logic prev_cv    = 1'b0;
   logic last_s_hit = 1'b1;

   always @(negedge clk) begin
      if (bus.ctrl_valid) issue_log.push_back(bus.ctrl_addr);
      viol <= viol + ((bus.ctrl_valid && prev_cv) ? 1 : 0)
                   + ((bus.respR_valid && bus.respS_valid) ? 1 : 0);
      prev_cv <= bus.ctrl_valid;
      if (bus.respR_valid) resp_r_cnt <= resp_r_cnt + 1;
      if (bus.respS_valid) begin
         resp_s_cnt <= resp_s_cnt + 1;
         last_s_hit <= bus.respS_hit;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] log_at(input int idx);
      if (idx < issue_log.size()) return {24'h0, issue_log[idx]};
      return 32'hDEAD;
   endfunction

   task automatic push_r(input logic [7:0] a);
      bus.reqR_valid  = 1'b1;
      bus.reqR_opcode = 1'b0;
      bus.reqR_addr   = a;
      tick;
      bus.reqR_valid  = 1'b0;
   endtask

   task automatic push_s(input logic [7:0] a);
      bus.reqS_valid  = 1'b1;
      bus.reqS_opcode = 1'b0;
      bus.reqS_addr   = a;
      tick;
      bus.reqS_valid  = 1'b0;
   endtask

   // Wait until the k-th logged issue, answer it from WAIT, optionally pushing R on the response edge.
   task automatic serve(input int k, input logic hit, input logic stall,
                        input logic pr, input logic [7:0] paddr);
      int guard = 0;
      while (issue_log.size() < k && guard < 200) begin
         tick;
         guard++;
      end
      check("issue_seen", {31'h0, issue_log.size() >= k}, 32'h1);
      tick;
      bus.ctrl_resp_valid = 1'b1;
      bus.ctrl_resp_hit   = hit;
      bus.ctrl_stall      = stall;
      if (pr) begin
         bus.reqR_valid  = 1'b1;
         bus.reqR_opcode = 1'b0;
         bus.reqR_addr   = paddr;
      end
      tick;
      bus.ctrl_resp_valid = 1'b0;
      bus.ctrl_resp_hit   = 1'b0;
      bus.ctrl_stall      = 1'b0;
      bus.reqR_valid      = 1'b0;
      if (stall) check("stall_reissue", {31'h0, bus.ctrl_valid}, 32'h1);
   endtask

   logic [7:0] fair_exp [6] = '{8'd1, 8'd9, 8'd2, 8'd10, 8'd3, 8'd11};

   initial begin
      int base, r0, s0, guard;
      bus.reqR_valid = 0; bus.reqR_opcode = 0; bus.reqR_addr = '0;
      bus.reqS_valid = 0; bus.reqS_opcode = 0; bus.reqS_addr = '0;
      bus.ctrl_resp_valid = 0; bus.ctrl_resp_hit = 0; bus.ctrl_stall = 0;

      // Reset then idle
      rst_n = 1'b0;
      repeat (3) tick;
      rst_n = 1'b1;
      tick;
      check("rst_ctrl_valid",  {31'h0, bus.ctrl_valid},  32'h0);
      check("rst_ctrl_opcode", {31'h0, bus.ctrl_opcode}, 32'h0);
      check("rst_ctrl_addr",   {24'h0, bus.ctrl_addr},   32'h0);
      check("rst_respR_valid", {31'h0, bus.respR_valid}, 32'h0);
      check("rst_respS_valid", {31'h0, bus.respS_valid}, 32'h0);
      check("rst_respR_hit",   {31'h0, bus.respR_hit},   32'h0);
      check("rst_respS_hit",   {31'h0, bus.respS_hit},   32'h0);
      check("rst_reqR_ready",  {31'h0, bus.reqR_ready},  32'h1);
      check("rst_reqS_ready",  {31'h0, bus.reqS_ready},  32'h1);
      base = issue_log.size();
      repeat (20) tick;
      check("idle_no_issue", issue_log.size(), base);

      // Single request: exact issue and response latency
      push_r(8'h2A);
      check("single_not_early", {31'h0, bus.ctrl_valid}, 32'h0);
      tick;
      check("single_issue",  {31'h0, bus.ctrl_valid},  32'h1);
      check("single_addr",   {24'h0, bus.ctrl_addr},   32'h2A);
      check("single_opcode", {31'h0, bus.ctrl_opcode}, 32'h0);
      tick;
      check("single_one_strobe", {31'h0, bus.ctrl_valid}, 32'h0);
      tick;
      bus.ctrl_resp_valid = 1'b1;
      bus.ctrl_resp_hit   = 1'b1;
      tick;
      bus.ctrl_resp_valid = 1'b0;
      bus.ctrl_resp_hit   = 1'b0;
      check("single_respR_valid", {31'h0, bus.respR_valid}, 32'h1);
      check("single_respR_hit",   {31'h0, bus.respR_hit},   32'h1);
      check("single_respS_valid", {31'h0, bus.respS_valid}, 32'h0);
      tick;
      check("single_resp_pulse", {31'h0, bus.respR_valid}, 32'h0);

      // Contention fairness, from a fresh reset so R wins first
      rst_n = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      base = issue_log.size();
      r0 = resp_r_cnt;
      s0 = resp_s_cnt;
      for (int i = 0; i < 3; i++) begin
         bus.reqR_valid = 1'b1; bus.reqR_opcode = 1'b0; bus.reqR_addr = 8'(i + 1);
         bus.reqS_valid = 1'b1; bus.reqS_opcode = 1'b0; bus.reqS_addr = 8'(i + 9);
         tick;
      end
      bus.reqR_valid = 1'b0;
      bus.reqS_valid = 1'b0;
      for (int n = 1; n <= 6; n++) serve(base + n, 1'b1, 1'b0, 1'b0, 8'h0);
      tick;
      for (int i = 0; i < 6; i++) check("fair_order", log_at(base + i), {24'h0, fair_exp[i]});
      check("fair_respR_cnt", resp_r_cnt - r0, 3);
      check("fair_respS_cnt", resp_s_cnt - s0, 3);

      // Stall retry with an R request queued behind it
      base = issue_log.size();
      r0 = resp_r_cnt;
      s0 = resp_s_cnt;
      push_s(8'h40);
      push_r(8'h55);
      serve(base + 1, 1'b0, 1'b1, 1'b0, 8'h0);
      serve(base + 2, 1'b0, 1'b1, 1'b0, 8'h0);
      serve(base + 3, 1'b0, 1'b0, 1'b0, 8'h0);
      serve(base + 4, 1'b1, 1'b0, 1'b0, 8'h0);
      tick;
      for (int i = 0; i < 3; i++) check("stall_addr", log_at(base + i), 32'h40);
      check("stall_r_after", log_at(base + 3), 32'h55);
      check("stall_issue_cnt", issue_log.size(), base + 4);
      check("stall_respS_cnt", resp_s_cnt - s0, 1);
      check("stall_respS_hit", {31'h0, last_s_hit}, 32'h0);
      check("stall_respR_cnt", resp_r_cnt - r0, 1);

      // FIFO full: fifth push dropped
      base = issue_log.size();
      for (int i = 0; i < 5; i++) begin
         bus.reqR_valid = 1'b1; bus.reqR_opcode = 1'b0; bus.reqR_addr = 8'(8'h10 + i);
         tick;
         check("full_ready", {31'h0, bus.reqR_ready}, (i < 3) ? 32'h1 : 32'h0);
      end
      bus.reqR_valid = 1'b0;
      serve(base + 1, 1'b0, 1'b0, 1'b0, 8'h0);
      check("full_ready_rise", {31'h0, bus.reqR_ready}, 32'h1);
      for (int n = 2; n <= 4; n++) serve(base + n, 1'b0, 1'b0, 1'b0, 8'h0);
      repeat (10) tick;
      check("full_drop_cnt", issue_log.size(), base + 4);
      for (int i = 0; i < 4; i++) check("full_order", log_at(base + i), 32'h10 + i);

      // Pointer wrap, including a push and pop on the same edge
      push_r(8'h20);
      push_r(8'h21);
      push_r(8'h22);
      serve(base + 5, 1'b0, 1'b0, 1'b1, 8'h23);
      push_r(8'h24);
      check("wrap_full", {31'h0, bus.reqR_ready}, 32'h0);
      serve(base + 6, 1'b0, 1'b0, 1'b0, 8'h0);
      push_r(8'h25);
      for (int n = 7; n <= 10; n++) serve(base + n, 1'b0, 1'b0, 1'b0, 8'h0);
      repeat (5) tick;
      check("wrap_cnt", issue_log.size(), base + 10);
      for (int i = 0; i < 6; i++) check("wrap_order", log_at(base + 4 + i), 32'h20 + i);

      // Reset while WAITing with entries queued
      base = issue_log.size();
      for (int i = 0; i < 2; i++) begin
         bus.reqR_valid = 1'b1; bus.reqR_opcode = 1'b0; bus.reqR_addr = 8'(8'h31 + 2 * i);
         bus.reqS_valid = 1'b1; bus.reqS_opcode = 1'b0; bus.reqS_addr = 8'(8'h32 + 2 * i);
         tick;
      end
      bus.reqR_valid = 1'b0;
      bus.reqS_valid = 1'b0;
      guard = 0;
      while (issue_log.size() < base + 1 && guard < 50) begin
         tick;
         guard++;
      end
      tick;
      r0 = resp_r_cnt;
      s0 = resp_s_cnt;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      repeat (10) tick;
      check("mid_rst_issue_cnt", issue_log.size(), base + 1);
      check("mid_rst_respR",     resp_r_cnt - r0, 0);
      check("mid_rst_respS",     resp_s_cnt - s0, 0);
      check("mid_rst_readyR",    {31'h0, bus.reqR_ready}, 32'h1);
      check("mid_rst_readyS",    {31'h0, bus.reqS_ready}, 32'h1);
      push_r(8'h77);
      check("mid_rst_not_early", {31'h0, bus.ctrl_valid}, 32'h0);
      tick;
      check("mid_rst_issue", {31'h0, bus.ctrl_valid}, 32'h1);
      check("mid_rst_addr",  {24'h0, bus.ctrl_addr},  32'h77);
      r0 = resp_r_cnt;
      serve(base + 2, 1'b1, 1'b0, 1'b0, 8'h0);
      tick;
      check("mid_rst_resp", resp_r_cnt - r0, 1);

      tick;
      check("invariants", viol, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
